// File: rtl/sobel_frame_engine.sv
// Sobel engine over one on-chip RGB frame; SOBEL_THRESH_EN adds a thresh port driving out_edge.
// Latency: read port 1 cycle; interior result valid 12 cycles after FETCH entry, border 2 cycles after POS.
// Backpressure: out_valid and all out_* hold until out_ready; the scan waits in EMIT meanwhile.
module sobel_frame_engine #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 10,
   parameter int CH_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [3*CH_W-1:0]      wr_data,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [3*CH_W-1:0]      data_out,
   input  logic                   sobel_start,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_addr,
   output logic signed [CH_W+2:0] out_gx,
   output logic signed [CH_W+2:0] out_gy,
   output logic [CH_W-1:0]        out_mag,
   output logic                   out_edge,
   output logic                   sobel_done
`ifdef SOBEL_THRESH_EN
   ,
   input  logic [CH_W-1:0]        thresh
`endif
);

   localparam int PIX_W = 3 * CH_W;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int GW    = CH_W + 3;
   localparam int SW    = CH_W + 2;
   localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam logic [ADDR_W:0]   NPIX_A  = (ADDR_W+1)'(NPIX);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NPIX - 1);
   localparam logic [GW-1:0]     MAX_MAG = GW'((1 << CH_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POS, S_FETCH, S_DRAIN, S_CALC, S_EMIT, S_DONE
   } state_t;

   state_t            state;
   logic [PIX_W-1:0]  mem [NPIX];
   logic [PIX_W-1:0]  scan_q;
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] fetch_addr;
   logic [XW-1:0]     cur_x;
   logic [YW-1:0]     cur_y;
   logic [3:0]        cnt;
   logic [CH_W-1:0]   win [9];

   logic              wr_ok, rd_ok, border, last_pix;
   logic [SW-1:0]     gsum;
   logic [CH_W-1:0]   gray;
   logic [SW-1:0]     gx_p, gx_n, gy_p, gy_n;
   logic signed [GW-1:0] gx_s, gy_s;
   logic [GW-1:0]     ax, ay, msum;
   logic [CH_W-1:0]   mag_c;
   logic              edge_c;

   assign wr_ok = ({1'b0, wr_addr} < NPIX_A);
   assign rd_ok = ({1'b0, rd_addr} < NPIX_A);

   // Frame RAM: external writes are locked out for the whole scan.
   always_ff @(posedge clk) begin
      if (wr_en && !busy && wr_ok)
         mem[wr_addr[IW-1:0]] <= wr_data;
      scan_q <= mem[fetch_addr[IW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         data_out <= '0;
      else if (!busy)
         data_out <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
   end

   assign gsum = {2'b00, scan_q[PIX_W-1 -: CH_W]}
               + {1'b0, scan_q[2*CH_W-1 -: CH_W], 1'b0}
               + {2'b00, scan_q[CH_W-1:0]};
   assign gray = CH_W'(gsum >> 2);

   // win[] holds the 3x3 neighbourhood row-major: win[0]=p00 ... win[8]=p22.
   assign gx_p = {2'b00, win[2]} + {1'b0, win[5], 1'b0} + {2'b00, win[8]};
   assign gx_n = {2'b00, win[0]} + {1'b0, win[3], 1'b0} + {2'b00, win[6]};
   assign gy_p = {2'b00, win[6]} + {1'b0, win[7], 1'b0} + {2'b00, win[8]};
   assign gy_n = {2'b00, win[0]} + {1'b0, win[1], 1'b0} + {2'b00, win[2]};
   assign gx_s = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
   assign gy_s = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
   assign ax   = gx_s[GW-1] ? $unsigned(-gx_s) : $unsigned(gx_s);
   assign ay   = gy_s[GW-1] ? $unsigned(-gy_s) : $unsigned(gy_s);
   assign msum = ax + ay;
   assign mag_c = (msum > MAX_MAG) ? CH_W'(MAX_MAG) : msum[CH_W-1:0];

`ifdef SOBEL_THRESH_EN
   assign edge_c = (mag_c >= thresh);
`else
   assign edge_c = 1'b0;
`endif

   assign border   = (cur_x == '0) || (cur_x == XW'(IMG_W - 1)) ||
                     (cur_y == '0) || (cur_y == YW'(IMG_H - 1));
   assign last_pix = (pix_addr == LAST_A);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         sobel_done <= 1'b0;
         out_addr   <= '0;
         out_gx     <= '0;
         out_gy     <= '0;
         out_mag    <= '0;
         out_edge   <= 1'b0;
         pix_addr   <= '0;
         fetch_addr <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         cnt        <= '0;
         for (int i = 0; i < 9; i++) win[i] <= '0;
      end else begin
         if ((state == S_FETCH && cnt != 4'd0) || state == S_DRAIN) begin
            for (int i = 0; i < 8; i++) win[i] <= win[i+1];
            win[8] <= gray;
         end
         case (state)
            S_IDLE: begin
               if (sobel_start) begin
                  busy     <= 1'b1;
                  pix_addr <= '0;
                  cur_x    <= '0;
                  cur_y    <= '0;
                  state    <= S_POS;
               end
            end
            S_POS: begin
               out_addr <= pix_addr;
               cnt      <= '0;
               if (border) begin
                  out_gx   <= '0;
                  out_gy   <= '0;
                  out_mag  <= '0;
                  out_edge <= 1'b0;
                  state    <= S_EMIT;
               end else begin
                  fetch_addr <= pix_addr - ADDR_W'(IMG_W + 1);
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               // Step along the row, jumping to the next row after each third tap.
               if (cnt == 4'd2 || cnt == 4'd5)
                  fetch_addr <= fetch_addr + ADDR_W'(IMG_W - 2);
               else
                  fetch_addr <= fetch_addr + ADDR_W'(1);
               cnt <= cnt + 4'd1;
               if (cnt == 4'd8)
                  state <= S_DRAIN;
            end
            S_DRAIN: state <= S_CALC;
            S_CALC: begin
               out_gx   <= gx_s;
               out_gy   <= gy_s;
               out_mag  <= mag_c;
               out_edge <= edge_c;
               state    <= S_EMIT;
            end
            S_EMIT: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last_pix) begin
                     sobel_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_DONE;
                  end else begin
                     pix_addr <= pix_addr + ADDR_W'(1);
                     if (cur_x == XW'(IMG_W - 1)) begin
                        cur_x <= '0;
                        cur_y <= cur_y + YW'(1);
                     end else begin
                        cur_x <= cur_x + XW'(1);
                     end
                     state <= S_POS;
                  end
               end
            end
            S_DONE: begin
               sobel_done <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Directed bench for sobel_frame_engine on a 4x4, 4-bit-per-channel frame.
module tb_sobel_frame_engine;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int AW = 10;
   localparam int CW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 wr_en = 1'b0;
   logic [AW-1:0]        wr_addr = '0;
   logic [3*CW-1:0]      wr_data = '0;
   logic [AW-1:0]        rd_addr = '0;
   logic [3*CW-1:0]      data_out;
   logic                 sobel_start = 1'b0;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [AW-1:0]        out_addr;
   logic signed [CW+2:0] out_gx;
   logic signed [CW+2:0] out_gy;
   logic [CW-1:0]        out_mag;
   logic                 out_edge;
   logic                 sobel_done;
   logic [CW-1:0]        thresh = 4'd8;

   int n_checks = 0;
   int n_errors = 0;
   int exp_gx  [16];
   int exp_gy  [16];
   int exp_mag [16];

   sobel_frame_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CH_W(CW)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .data_out(data_out),
      .sobel_start(sobel_start), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag), .out_edge(out_edge),
      .sobel_done(sobel_done)
`ifdef SOBEL_THRESH_EN
      , .thresh(thresh)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: all white; 1: left half black, right half white; 2: black with addr 6 = 12'h111
   task automatic load_frame(input int mode);
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = AW'(a);
         case (mode)
            0:       wr_data = 12'hFFF;
            1:       wr_data = ((a % 4) >= 2) ? 12'hFFF : 12'h000;
            default: wr_data = (a == 6) ? 12'h111 : 12'h000;
         endcase
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic set_exp(input int mode);
      for (int a = 0; a < 16; a++) begin
         exp_gx[a] = 0; exp_gy[a] = 0; exp_mag[a] = 0;
      end
      if (mode == 1) begin
         exp_gx[5] = 60;  exp_mag[5]  = 15;
         exp_gx[6] = 60;  exp_mag[6]  = 15;
         exp_gx[9] = 60;  exp_mag[9]  = 15;
         exp_gx[10] = 60; exp_mag[10] = 15;
      end else if (mode == 2) begin
         exp_gx[5] = 2;                    exp_mag[5]  = 2;
         exp_gx[9] = 1;  exp_gy[9] = -1;   exp_mag[9]  = 2;
         exp_gy[10] = -2;                  exp_mag[10] = 2;
      end
   endtask

   task automatic run_scan(input int stall_at, input int rst_at, input bit disturb);
      int got = 0;
      int cyc = 0;
      int stall_left = 5;
      int lat_ref = -1;
      int early_done = 0;
      int a, e_edge, s_addr, s_gx, s_gy, s_mag, n_done;
      @(negedge clk);
      sobel_start = 1'b1;
      @(negedge clk);
      sobel_start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      while (got < 16 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         sobel_start = disturb && (got == 3);
         wr_en       = sobel_start;
         wr_addr     = AW'(5);
         wr_data     = 12'hFFF;
         if (sobel_done) early_done++;
         a = int'(out_addr);
         if (out_valid && a == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_busy", int'(busy), 0);
            check("rst_valid", int'(out_valid), 0);
            rst = 1'b0;
            out_ready = 1'b1;
            n_done = 0;
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               if (sobel_done) n_done++;
            end
            check("rst_no_done", n_done, 0);
            check("rst_idle_busy", int'(busy), 0);
            return;
         end
         if (out_valid && a == stall_at && stall_left > 0) begin
            if (stall_left == 5) begin
               s_addr = a; s_gx = int'(out_gx); s_gy = int'(out_gy); s_mag = int'(out_mag);
            end else begin
               check("stall_addr", a, s_addr);
               check("stall_gx", int'(out_gx), s_gx);
               check("stall_gy", int'(out_gy), s_gy);
               check("stall_mag", int'(out_mag), s_mag);
            end
            out_ready = 1'b0;
            stall_left--;
         end else if (out_valid) begin
            out_ready = 1'b1;
            if (a == 4) lat_ref = cyc;
            if (a == 5 && stall_at != 5) check("latency_addr5", cyc - lat_ref, 14);
            check("addr_order", a, got);
            check($sformatf("gx@%0d", got), int'(out_gx), exp_gx[got]);
            check($sformatf("gy@%0d", got), int'(out_gy), exp_gy[got]);
            check($sformatf("mag@%0d", got), int'(out_mag), exp_mag[got]);
`ifdef SOBEL_THRESH_EN
            e_edge = (exp_gx[got] != 0 || exp_gy[got] != 0) && (exp_mag[got] >= int'(thresh)) ? 1 : 0;
`else
            e_edge = 0;
`endif
            check($sformatf("edge@%0d", got), int'(out_edge), e_edge);
            got++;
         end else begin
            out_ready = 1'b1;
         end
      end
      sobel_start = 1'b0;
      wr_en = 1'b0;
      check("result_count", got, 16);
      check("done_early", early_done, 0);
      @(negedge clk);
      check("done_pulse", int'(sobel_done), 1);
      check("busy_at_done", int'(busy), 0);
      @(negedge clk);
      check("done_cleared", int'(sobel_done), 0);
      check("busy_after", int'(busy), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy0", int'(busy), 0);
      check("rst_valid0", int'(out_valid), 0);
      check("rst_done0", int'(sobel_done), 0);
      check("rst_edge0", int'(out_edge), 0);
      check("rst_addr0", int'(out_addr), 0);
      check("rst_gx0", int'(out_gx), 0);
      check("rst_gy0", int'(out_gy), 0);
      check("rst_mag0", int'(out_mag), 0);
      check("rst_dout0", int'(data_out), 0);
      rst = 1'b0;

      load_frame(0); set_exp(0);
      run_scan(-1, -1, 1'b0);

      load_frame(1); set_exp(1);
      run_scan(-1, -1, 1'b0);

      load_frame(2); set_exp(2);
      run_scan(-1, -1, 1'b0);
      @(negedge clk); rd_addr = AW'(6);
      @(negedge clk); check("read_addr6", int'(data_out), 'h111);
      rd_addr = '0; wr_en = 1'b1; wr_addr = '0; wr_data = 12'hABC;
      @(negedge clk); wr_en = 1'b0;
      check("rw_same_old", int'(data_out), 0);
      @(negedge clk); check("rw_same_new", int'(data_out), 'hABC);

      load_frame(1); set_exp(1);
      run_scan(5, -1, 1'b0);
      run_scan(-1, -1, 1'b1);
      @(negedge clk); rd_addr = AW'(5);
      @(negedge clk); check("write_blocked", int'(data_out), 0);
      run_scan(-1, 9, 1'b0);
      run_scan(-1, -1, 1'b0);

      load_frame(2); set_exp(2);
      thresh = 4'd2;
      run_scan(-1, -1, 1'b0);
      thresh = 4'd3;
      run_scan(-1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
